// File: rtl/eth_tx_framer_if.sv
// Handshake bundle between the upstream payload serializer and the RMII TX framer.
interface eth_tx_framer_if;
  logic       tx_en;
  logic       axiiv;
  logic [1:0] axiid;
  logic       stall;
  logic       axiov;
  logic [1:0] axiod;
  logic       frame_done;
  logic       underrun;

  modport master (output tx_en, axiiv, axiid,
                  input  stall, axiov, axiod, frame_done, underrun);
  modport slave  (input  tx_en, axiiv, axiid,
                  output stall, axiov, axiod, frame_done, underrun);
endinterface

// File: rtl/eth_tx_framer.sv
// RMII dibit Ethernet TX framer: preamble, SFD, fixed header, streamed payload, optional FCS.
// Define ETH_FCS_EN to build the CRC-32 generator and the FCS state.
module eth_tx_framer #(
  parameter logic [47:0] DST_MAC       = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC       = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5,
  parameter int          PAYLOAD_BYTES = 323,
  parameter int          IFG_DIBITS    = 48
) (
  input logic            clk,
  input logic            rst,
  eth_tx_framer_if.slave bus
);
  localparam int PAY_DIBITS = PAYLOAD_BYTES * 4;
  localparam int CNT_MAX = (PAY_DIBITS > IFG_DIBITS) ? ((PAY_DIBITS > 56) ? PAY_DIBITS : 56)
                                                     : ((IFG_DIBITS > 56) ? IFG_DIBITS : 56);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PRE_LAST  = CW'(27);
  localparam logic [CW-1:0] SFD_LAST  = CW'(3);
  localparam logic [CW-1:0] HDR_STALL = CW'(54);
  localparam logic [CW-1:0] HDR_LAST  = CW'(55);
  localparam logic [CW-1:0] PAY_LAST  = CW'(PAY_DIBITS - 1);
  localparam logic [CW-1:0] IFG_LAST  = CW'(IFG_DIBITS - 1);
  localparam logic [111:0]  HDR       = {DST_MAC, SRC_MAC, ETHERTYPE};

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG} state_t;

  state_t          r_state, w_nstate;
  logic [CW-1:0]   r_cnt, w_ncnt;
  logic            r_stall, r_vld, r_done, r_urun;
  logic [1:0]      r_dibit;
  logic            w_cap, w_urun, w_nstall, w_nvld, w_ndone;
  logic [1:0]      w_ndibit;
  logic [6:0]      w_hidx;

`ifdef ETH_FCS_EN
  localparam logic [CW-1:0] FCS_LAST = CW'(15);
  logic [31:0] r_crc;

  function automatic logic [31:0] crc2(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++)
      r = (r >> 1) ^ (((r[0] ^ d[i]) != 1'b0) ? 32'hEDB8_8320 : 32'h0);
    return r;
  endfunction
`endif

  // Outputs are registered from the next state, so r_state/r_cnt name the dibit on the wire.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt + 1'b1;
    w_cap    = 1'b0;
    w_urun   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ncnt = '0;
        if (bus.tx_en) w_nstate = PREAMBLE;
      end
      PREAMBLE: if (r_cnt == PRE_LAST) begin w_nstate = SFD;    w_ncnt = '0; end
      SFD:      if (r_cnt == SFD_LAST) begin w_nstate = HEADER; w_ncnt = '0; end
      HEADER: if (r_cnt == HDR_LAST) begin
        w_cap    = 1'b1;
        w_nstate = PAYLOAD;
        w_ncnt   = '0;
      end
      PAYLOAD: begin
        w_cap = (r_cnt != PAY_LAST);
        if (r_cnt == PAY_LAST) begin
`ifdef ETH_FCS_EN
          w_nstate = FCS;
`else
          w_nstate = IFG;
`endif
          w_ncnt = '0;
        end
      end
`ifdef ETH_FCS_EN
      FCS: if (r_cnt == FCS_LAST) begin w_nstate = IFG; w_ncnt = '0; end
`endif
      IFG: if (r_cnt == IFG_LAST) begin
        w_nstate = bus.tx_en ? PREAMBLE : IDLE;
        w_ncnt   = '0;
      end
      default: begin w_nstate = IDLE; w_ncnt = '0; end
    endcase
    if (w_cap && !bus.axiiv) begin
      w_urun   = 1'b1;
      w_nstate = IFG;
      w_ncnt   = '0;
    end

    // Header bytes go out MSB-first, each byte LSb-pair first.
    w_hidx   = 7'd104 - {w_ncnt[5:2], 3'b000} + {4'b0000, w_ncnt[1:0], 1'b0};
    w_ndibit = 2'b00;
    case (w_nstate)
      PREAMBLE: w_ndibit = 2'b01;
      SFD:      w_ndibit = (w_ncnt == SFD_LAST) ? 2'b11 : 2'b01;
      HEADER:   w_ndibit = 2'(HDR >> w_hidx);
      PAYLOAD:  w_ndibit = bus.axiid;
`ifdef ETH_FCS_EN
      FCS:      w_ndibit = 2'(~r_crc >> {w_ncnt[3:0], 1'b0});
`endif
      default:  w_ndibit = 2'b00;
    endcase
    w_nvld   = (w_nstate != IDLE) && (w_nstate != IFG);
    w_nstall = !(((w_nstate == HEADER) && (w_ncnt >= HDR_STALL)) ||
                 ((w_nstate == PAYLOAD) && (w_ncnt != PAY_LAST)));
`ifdef ETH_FCS_EN
    w_ndone  = (w_nstate == FCS) && (w_ncnt == FCS_LAST);
`else
    w_ndone  = (w_nstate == PAYLOAD) && (w_ncnt == PAY_LAST);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_stall <= 1'b1;
      r_vld   <= 1'b0;
      r_dibit <= 2'b00;
      r_done  <= 1'b0;
      r_urun  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_stall <= w_nstall;
      r_vld   <= w_nvld;
      r_dibit <= w_ndibit;
      r_done  <= w_ndone;
      r_urun  <= r_urun | w_urun;
    end
  end

`ifdef ETH_FCS_EN
  // CRC follows exactly the header/payload dibits as they are loaded onto the wire.
  always_ff @(posedge clk) begin
    if (rst || (w_nstate == PREAMBLE))
      r_crc <= 32'hFFFF_FFFF;
    else if ((w_nstate == HEADER) || (w_nstate == PAYLOAD))
      r_crc <= crc2(r_crc, w_ndibit);
  end
`endif

  assign bus.stall      = r_stall;
  assign bus.axiov      = r_vld;
  assign bus.axiod      = r_dibit;
  assign bus.frame_done = r_done;
  assign bus.underrun   = r_urun;
endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: scoreboard of expected wire dibits plus an upstream model
// that answers stall with one cycle of latency.
module tb_eth_tx_framer;
  localparam logic [47:0] DST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC   = 48'h02_00_00_00_00_01;
  localparam logic [15:0] ETYPE = 16'h88B5;
  localparam int NBYTES  = 46;
  localparam int NFB     = 14 + NBYTES;
  localparam int PAY_DIB = NBYTES * 4;
  localparam int IFG     = 48;
`ifdef ETH_FCS_EN
  localparam bit FCS_ON    = 1'b1;
  localparam int FRAME_LEN = 288;
`else
  localparam bit FCS_ON    = 1'b0;
  localparam int FRAME_LEN = 272;
`endif

  typedef struct packed { logic [1:0] d; logic done; logic stall; } exp_t;

  logic clk, rst;
  eth_tx_framer_if ifc();

  eth_tx_framer #(
    .DST_MAC(DST), .SRC_MAC(SRC), .ETHERTYPE(ETYPE),
    .PAYLOAD_BYTES(NBYTES), .IFG_DIBITS(IFG)
  ) dut (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] pay [NBYTES];
  bit         mon_en = 1'b0;
  int         gap_at = -1;
  int         up_idx = 0;
  logic       up_stall_q = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] pay_dib(input int i);
    logic [7:0] b;
    b = pay[i / 4];
    return b[2 * (i % 4) +: 2];
  endfunction

  // Queue every dibit the wire must carry; npay limits payload dibits for a truncated frame.
  task automatic push_frame(input int npay, input bit full);
    logic [7:0]   fb [NFB];
    logic [111:0] hdr;
    logic [31:0]  c;
    logic [7:0]   b;
    exp_t         e;
    hdr = {DST, SRC, ETYPE};
    for (int i = 0; i < 14; i++) fb[i] = hdr[111 - 8 * i -: 8];
    for (int i = 0; i < NBYTES; i++) fb[14 + i] = pay[i];
    for (int k = 0; k < 32; k++) begin
      e.d = (k == 31) ? 2'b11 : 2'b01;
      e.done = 1'b0;
      e.stall = 1'b1;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 56 + npay; k++) begin
      b = fb[k / 4];
      e.d = b[2 * (k % 4) +: 2];
      e.stall = (k < 54) || (k == 56 + PAY_DIB - 1);
      e.done = full && !FCS_ON && (k == 56 + PAY_DIB - 1);
      exp_q.push_back(e);
    end
    if (full && FCS_ON) begin
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < NFB; i++)
        for (int j = 0; j < 8; j++)
          c = (c >> 1) ^ (((c[0] ^ fb[i][j]) != 1'b0) ? 32'hEDB8_8320 : 32'h0);
      c = ~c;
      for (int k = 0; k < 16; k++) begin
        e.d = c[2 * k +: 2];
        e.stall = 1'b1;
        e.done = (k == 15);
        exp_q.push_back(e);
      end
    end
  endtask

  // Upstream serializer: reacts to the stall value seen one cycle earlier.
  always @(negedge clk) begin
    if (ifc.axiiv === 1'b1) up_idx++;
    if (ifc.stall === 1'b1 && up_stall_q) up_idx = 0;
    ifc.axiiv = !up_stall_q && (up_idx != gap_at);
    ifc.axiid = (up_idx < PAY_DIB) ? pay_dib(up_idx) : 2'b00;
    up_stall_q = (ifc.stall !== 1'b0);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (ifc.axiov === 1'b1) begin
        check("dibit_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("axiod", 32'(ifc.axiod), 32'(mon_e.d));
          check("frame_done", 32'(ifc.frame_done), 32'(mon_e.done));
          check("stall", 32'(ifc.stall), 32'(mon_e.stall));
        end
      end else begin
        check("idle_frame_done", 32'(ifc.frame_done), 32'd0);
        check("idle_stall", 32'(ifc.stall), 32'd1);
      end
    end
  end

  task automatic wait_on(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (ifc.axiov !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(ifc.axiov === lvl), 32'd1);
  endtask

  task automatic run_len(input logic lvl, input int budget, output int n);
    n = 0;
    while (ifc.axiov === lvl && n < budget) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    ifc.tx_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(ifc.stall), 32'd1);
    check("rst_axiov", 32'(ifc.axiov), 32'd0);
    check("rst_axiod", 32'(ifc.axiod), 32'd0);
    check("rst_frame_done", 32'(ifc.frame_done), 32'd0);
    check("rst_underrun", 32'(ifc.underrun), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);

    // single frame, zero payload, tx_en pulsed
    foreach (pay[i]) pay[i] = 8'h00;
    push_frame(PAY_DIB, 1'b1);
    ifc.tx_en = 1'b1;
    @(negedge clk);
    ifc.tx_en = 1'b0;
    wait_on(1'b1, 50, "f1_start");
    run_len(1'b1, 2000, n);
    check("f1_len", n, FRAME_LEN);
    check("f1_q_empty", exp_q.size(), 0);
    check("f1_underrun", 32'(ifc.underrun), 32'd0);
    run_len(1'b0, 200, n);
    check("f1_idle", n, 200);

    // back-to-back, tx_en dropped during the second frame
    foreach (pay[i]) pay[i] = 8'(i * 37 + 5);
    push_frame(PAY_DIB, 1'b1);
    push_frame(PAY_DIB, 1'b1);
    ifc.tx_en = 1'b1;
    wait_on(1'b1, 50, "b2b_start");
    run_len(1'b1, 2000, n);
    check("b2b_len1", n, FRAME_LEN);
    run_len(1'b0, 200, n);
    check("b2b_gap", n, IFG);
    ifc.tx_en = 1'b0;
    run_len(1'b1, 2000, n);
    check("b2b_len2", n, FRAME_LEN);
    run_len(1'b0, 200, n);
    check("b2b_idle", n, 200);
    check("b2b_q_empty", exp_q.size(), 0);

    // underrun at payload dibit 10, then a clean frame after the gap
    foreach (pay[i]) pay[i] = 8'(8'hA5 ^ (i * 3));
    gap_at = 10;
    push_frame(10, 1'b0);
    push_frame(PAY_DIB, 1'b1);
    ifc.tx_en = 1'b1;
    wait_on(1'b1, 50, "ur_start");
    run_len(1'b1, 2000, n);
    check("ur_len", n, 28 + 4 + 56 + 10);
    check("ur_flag", 32'(ifc.underrun), 32'd1);
    gap_at = -1;
    run_len(1'b0, 200, n);
    check("ur_ifg", n, IFG);
    ifc.tx_en = 1'b0;
    run_len(1'b1, 2000, n);
    check("ur_next_len", n, FRAME_LEN);
    check("ur_sticky", 32'(ifc.underrun), 32'd1);
    run_len(1'b0, 100, n);
    check("ur_idle", n, 100);
    check("ur_q_empty", exp_q.size(), 0);

    // reset for 3 cycles in the middle of the header
    foreach (pay[i]) pay[i] = 8'h00;
    push_frame(PAY_DIB, 1'b1);
    ifc.tx_en = 1'b1;
    @(negedge clk);
    ifc.tx_en = 1'b0;
    wait_on(1'b1, 50, "rh_start");
    repeat (40) @(negedge clk);
    check("rh_in_frame", 32'(ifc.axiov), 32'd1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rh_stall", 32'(ifc.stall), 32'd1);
    check("rh_axiov", 32'(ifc.axiov), 32'd0);
    check("rh_axiod", 32'(ifc.axiod), 32'd0);
    check("rh_underrun", 32'(ifc.underrun), 32'd0);
    check("rh_frame_done", 32'(ifc.frame_done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    run_len(1'b0, 150, n);
    check("rh_idle", n, 150);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 The block SHALL have parameter DST_MAC, default 48'hFFFF_FFFF_FFFF, destination MAC, sent most-significant byte first.
REQ-002 The block SHALL have parameter SRC_MAC, default 48'h02_00_00_00_00_01, source MAC, sent most-significant byte first.
REQ-003 The block SHALL have parameter ETHERTYPE, default 16'h88B5, sent most-significant byte first.
REQ-004 The block SHALL have parameter PAYLOAD_BYTES, default 323, fixed payload length; legal range is 46 to 1500.
REQ-005 The block SHALL have parameter IFG_DIBITS, default 48, idle dibits between frames.
REQ-006 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-007 clk  input  1  RMII 50 MHz clock.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 tx_en  input  1  frame start request, sampled in IDLE.
REQ-010 axiiv  input  1  upstream payload dibit valid.
REQ-011 axiid  input  2  upstream payload dibit, LSb-pair first per byte.
REQ-012 stall  output  1  registered; holds the upstream serializer when high.
REQ-013 axiov  output  1  registered; RMII TX_EN.
REQ-014 axiod  output  2  registered; RMII TXD.
REQ-015 frame_done  output  1  one-cycle pulse on the last FCS dibit.
REQ-016 underrun  output  1  sticky; cleared only by rst.

Function
REQ-017 The state machine SHALL have states IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG.
- IDLE to PREAMBLE when tx_en=1.
- PREAMBLE: 28 dibits of 2'b01.
- SFD: 4 dibits 01,01,01,11 (0xD5).
- HEADER: 56 dibits, DST_MAC then SRC_MAC then ETHERTYPE, each byte LSb pair first.
- PAYLOAD: PAYLOAD_BYTES*4 dibits.
- FCS: 16 dibits.
- IFG: IFG_DIBITS cycles with axiov=0.
- After IFG: to PREAMBLE if tx_en=1, else to IDLE.
REQ-018 axiov SHALL be 1 in every cycle from the first preamble dibit through the last FCS dibit with no gaps, and 0 otherwise.
REQ-019 stall SHALL be 1 at all times except from the cycle in which header dibit 54 (0-based) is driven through the cycle in which the last payload dibit is captured.
REQ-020 A payload dibit captured with axiiv=1 at edge n SHALL appear on axiod in cycle n+1 (1-cycle latency), so that payload dibit 0 directly follows header dibit 55.
REQ-021 Dibits presented after the final payload dibit has been captured SHALL be ignored.
REQ-022 Underrun: if axiiv=0 in any PAYLOAD capture cycle, the block SHALL do all of the following:
- drive axiov=0 from the next cycle;
- set underrun=1;
- skip FCS and frame_done;
- go to IFG with stall=1.
REQ-023 The CRC SHALL be CRC-32 with reflected polynomial 32'hEDB88320 and init 32'hFFFF_FFFF, updated 2 bits per cycle over the header and payload only.
REQ-024 The FCS SHALL be the bitwise complement of the CRC, sent crc[1:0] first and crc[31:30] last.
REQ-025 Dropping tx_en mid-frame SHALL NOT truncate the frame; it affects only the decision taken after IFG.
REQ-026 All counters SHALL be sized to hold their maximum count without wrap; the payload counter SHALL reset to 0 at each PAYLOAD entry.

Reset
REQ-027 When rst=1, the outputs SHALL take these values at the next edge: stall=1, axiov=0, axiod=2'b00, frame_done=0, underrun=0.
REQ-028 When rst=1, the state SHALL go to IDLE and the CRC register SHALL be set to 32'hFFFF_FFFF.
REQ-029 A reset mid-frame SHALL abort the frame immediately, with no FCS sent and no frame_done pulse.

Configuration
REQ-030 With macro ETH_FCS_EN defined, the FCS state and CRC logic SHALL be present, and frame_done SHALL pulse on the last FCS dibit.
REQ-031 Without ETH_FCS_EN, the CRC logic SHALL be absent and PAYLOAD SHALL go directly to IFG.
- frame_done SHALL then pulse on the last payload dibit.
- The header, payload and stall timing SHALL be unchanged.

Verification
REQ-032 Reset scenario: assert rst for 3 cycles mid-HEADER -> next cycle stall=1, axiov=0, axiod=00, underrun=0, and the block stays idle with tx_en=0.
REQ-033 Single frame: PAYLOAD_BYTES=46, zero payload, tx_en pulsed -> exactly 288 contiguous axiov cycles.
- Dibits 0-31 SHALL equal 55x7 followed by D5.
- The FCS SHALL equal zlib crc32 of the 60 header+payload bytes, sent LSb first.
- frame_done SHALL be high on cycle 288.
REQ-034 Stall handshake: an upstream model with a 1-cycle stall-to-valid latency -> stall falls during header dibit 54, no axiov gap between header and payload, and stall rises the cycle after the last payload capture.
REQ-035 Underrun: axiiv forced low at payload dibit 10 -> axiov=0 on the following cycle, underrun=1, no frame_done, then 48 idle cycles.
REQ-036 Back-to-back: tx_en held high for 2 frames -> exactly 48 axiov-low cycles between the last FCS dibit and the next preamble.
REQ-037 ETH_FCS_EN undefined, PAYLOAD_BYTES=46 -> 272 axiov cycles per frame, and frame_done on the last payload dibit.
